// File: rtl/uart_alu_intf.sv
`timescale 1ns/1ps
// Frame collector between the UART receiver and a combinational ALU: gathers A, B, opcode,
// launches the result to the transmitter. Optional inter-byte timeout: UART_ALU_TIMEOUT_EN.
module uart_alu_intf #(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int NB_TOUT       = 16,
  parameter int TIMEOUT_TICKS = 50000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_overrun,
  output logic               o_timeout
);

  typedef enum logic [5:0] {
    ST_A       = 6'b000001,
    ST_B       = 6'b000010,
    ST_OP      = 6'b000100,
    ST_EXEC    = 6'b001000,
    ST_SEND    = 6'b010000,
    ST_WAIT_TX = 6'b100000
  } state_t;

  state_t               state, state_next;
  logic [NB_DATA-1:0]   a_reg, b_reg, tx_reg;
  logic [NB_OP-1:0]     op_reg;
  logic                 overrun_reg;
  logic                 tout_fire;

`ifdef UART_ALU_TIMEOUT_EN
  logic [NB_TOUT-1:0] tout_cnt;
  logic               timeout_reg;
  logic               in_frame;

  assign in_frame  = (state == ST_B) || (state == ST_OP);
  // A byte arriving together with the expiring tick takes priority over the timeout.
  assign tout_fire = in_frame && i_tick && !i_rx_done &&
                     (tout_cnt == NB_TOUT'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      tout_cnt    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= tout_fire;
      if (!in_frame || i_rx_done)
        tout_cnt <= '0;
      else if (i_tick)
        tout_cnt <= tout_cnt + NB_TOUT'(1);
    end
  end

  assign o_timeout = timeout_reg;
`else
  logic               unused_tick;
  logic [NB_TOUT-1:0] unused_tout;

  assign unused_tick = i_tick;
  assign unused_tout = NB_TOUT'(TIMEOUT_TICKS);
  assign tout_fire   = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)
      state <= ST_A;
    else
      state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_next = state;
    case (state)
      ST_A:       if (i_rx_done) state_next = ST_B;
      ST_B:       if (i_rx_done) state_next = ST_OP;
                  else if (tout_fire) state_next = ST_A;
      ST_OP:      if (i_rx_done) state_next = ST_EXEC;
                  else if (tout_fire) state_next = ST_A;
      ST_EXEC:    state_next = ST_SEND;
      ST_SEND:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) state_next = ST_A;
      default:    state_next = ST_A;
    endcase
  end

  always_comb begin
    o_tx_start = (state == ST_SEND);
  end

  // Operands are written only in their capture state, so the ALU inputs hold through the send.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      tx_reg      <= '0;
      overrun_reg <= 1'b0;
    end else begin
      case (state)
        ST_A: if (i_rx_done) begin
          a_reg       <= i_rx_data;
          overrun_reg <= 1'b0;
        end
        ST_B:  if (i_rx_done) b_reg <= i_rx_data;
        ST_OP: if (i_rx_done) op_reg <= i_rx_data[NB_OP-1:0];
        ST_EXEC: begin
          tx_reg <= i_alu_result;
          if (i_rx_done) overrun_reg <= 1'b1;
        end
        ST_SEND, ST_WAIT_TX: if (i_rx_done) overrun_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_data_a  = a_reg;
  assign o_data_b  = b_reg;
  assign o_op      = op_reg;
  assign o_tx_data = tx_reg;
  assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_uart_alu_intf.sv
`timescale 1ns/1ps
// Directed bench for uart_alu_intf; the ALU is modelled as an 8-bit wrapping A+B.
module tb_uart_alu_intf;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic [NB_DATA-1:0] i_rx_data = '0;
  logic               i_rx_done = 1'b0;
  logic               i_tx_done = 1'b0;
  logic               i_tick = 1'b0;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_data_a, o_data_b, o_tx_data;
  logic [NB_OP-1:0]   o_op;
  logic               o_tx_start, o_overrun, o_timeout;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign i_alu_result = o_data_a + o_data_b;

  uart_alu_intf #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_TOUT(16), .TIMEOUT_TICKS(4)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_tick(i_tick), .i_alu_result(i_alu_result),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    i_tick = 1'b1;
    @(negedge clk);
    i_tick = 1'b0;
  endtask

  // Sends a full frame; samples tx_start in N+1..N+3, op in N+1 and tx_data in N+2.
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          output logic s1, output logic s2, output logic s3,
                          output logic [5:0] op1, output logic [7:0] d2);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    s1  = o_tx_start;
    op1 = o_op;
    @(negedge clk);
    s2 = o_tx_start;
    d2 = o_tx_data;
    @(negedge clk);
    s3 = o_tx_start;
  endtask

  task automatic test_reset();
    logic [32:0] outs;
    @(negedge clk);
    outs = {o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_overrun, o_timeout};
    total++;
    if (outs !== 33'd0) $display("FAIL reset_hold: got %h want 0", outs);
    else passed++;
    i_rst = 1'b0;
    @(negedge clk);
    outs = {o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_overrun, o_timeout};
    total++;
    if (outs !== 33'd0) $display("FAIL reset_release: got %h want 0", outs);
    else passed++;
  endtask

  task automatic test_basic();
    logic s1, s2, s3;
    logic [5:0] op1;
    logic [7:0] d2;
    do_frame(8'h05, 8'h03, 8'h20, s1, s2, s3, op1, d2);
    total++;
    if ({o_data_a, o_data_b} !== 16'h0503) $display("FAIL basic_operands: got %h want 0503", {o_data_a, o_data_b});
    else passed++;
    total++;
    if (op1 !== 6'h20) $display("FAIL basic_op_n1: got %h want 20", op1);
    else passed++;
    total++;
    if ({s1, s2, s3} !== 3'b010) $display("FAIL basic_start_timing: got %b want 010", {s1, s2, s3});
    else passed++;
    total++;
    if (d2 !== 8'h08) $display("FAIL basic_tx_data: got %h want 08", d2);
    else passed++;
    pulse_tx_done();
  endtask

  task automatic test_opcode_mask();
    logic s1, s2, s3;
    logic [5:0] op1;
    logic [7:0] d2;
    do_frame(8'hFF, 8'h01, 8'hE0, s1, s2, s3, op1, d2);
    total++;
    if (op1 !== 6'h20) $display("FAIL mask_op: got %h want 20", op1);
    else passed++;
    total++;
    if ({s2, d2} !== 9'h100) $display("FAIL mask_tx_wrap: got start=%b data=%h want 1/00", s2, d2);
    else passed++;
    pulse_tx_done();
  endtask

  task automatic test_overrun();
    logic s1, s2, s3;
    logic [5:0] op1;
    logic [7:0] d2;
    do_frame(8'h10, 8'h20, 8'h01, s1, s2, s3, op1, d2);
    total++;
    if (d2 !== 8'h30) $display("FAIL ovr_tx_data: got %h want 30", d2);
    else passed++;
    send_byte(8'h55);
    total++;
    if ({o_overrun, o_data_a, o_data_b} !== 17'h11020) $display("FAIL ovr_set: got ovr=%b a=%h b=%h want 1/10/20", o_overrun, o_data_a, o_data_b);
    else passed++;
    pulse_tx_done();
    total++;
    if (o_overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", o_overrun);
    else passed++;
    send_byte(8'h01);
    total++;
    if ({o_overrun, o_data_a} !== 9'h001) $display("FAIL ovr_clear: got ovr=%b a=%h want 0/01", o_overrun, o_data_a);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [32:0] outs;
    logic s1, s2, s3;
    logic [5:0] op1;
    logic [7:0] d2;
    send_byte(8'h09);
    @(negedge clk);
    #2 i_rst = 1'b1;
    #1;
    outs = {o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_overrun, o_timeout};
    total++;
    if (outs !== 33'd0) $display("FAIL async_reset: got %h want 0", outs);
    else passed++;
    @(negedge clk);
    i_rst = 1'b0;
    do_frame(8'h02, 8'h02, 8'h20, s1, s2, s3, op1, d2);
    total++;
    if ({s2, d2} !== 9'h104) $display("FAIL after_reset_tx: got start=%b data=%h want 1/04", s2, d2);
    else passed++;
    pulse_tx_done();
  endtask

  task automatic test_simultaneous();
    logic s1, s2, s3;
    logic [5:0] op1;
    logic [7:0] d2;
    do_frame(8'h11, 8'h22, 8'h03, s1, s2, s3, op1, d2);
    @(negedge clk);
    i_rx_data = 8'h66;
    i_rx_done = 1'b1;
    i_tx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    total++;
    if ({o_overrun, o_data_a} !== 9'h111) $display("FAIL simul_drop: got ovr=%b a=%h want 1/11", o_overrun, o_data_a);
    else passed++;
    send_byte(8'h44);
    total++;
    if ({o_overrun, o_data_a} !== 9'h044) $display("FAIL simul_back_to_a: got ovr=%b a=%h want 0/44", o_overrun, o_data_a);
    else passed++;
    send_byte(8'h00);
    send_byte(8'h20);
    @(negedge clk);
    total++;
    if ({o_tx_start, o_tx_data} !== 9'h144) $display("FAIL simul_tx: got start=%b data=%h want 1/44", o_tx_start, o_tx_data);
    else passed++;
    pulse_tx_done();
  endtask

`ifdef UART_ALU_TIMEOUT_EN
  task automatic test_timeout();
    logic s1, s2, s3;
    logic [5:0] op1;
    logic [7:0] d2;
    send_byte(8'h07);
    repeat (3) pulse_tick();
    total++;
    if (o_timeout !== 1'b0) $display("FAIL tout_early: got %b want 0", o_timeout);
    else passed++;
    pulse_tick();
    total++;
    if ({o_timeout, o_data_a} !== 9'h107) $display("FAIL tout_pulse: got tout=%b a=%h want 1/07", o_timeout, o_data_a);
    else passed++;
    @(negedge clk);
    total++;
    if (o_timeout !== 1'b0) $display("FAIL tout_one_cycle: got %b want 0", o_timeout);
    else passed++;
    do_frame(8'h01, 8'h01, 8'h20, s1, s2, s3, op1, d2);
    total++;
    if ({s2, d2} !== 9'h102) $display("FAIL tout_next_frame: got start=%b data=%h want 1/02", s2, d2);
    else passed++;
    pulse_tx_done();
    // Byte coinciding with the expiring tick must be accepted.
    send_byte(8'h09);
    repeat (3) pulse_tick();
    @(negedge clk);
    i_rx_data = 8'h0A;
    i_rx_done = 1'b1;
    i_tick    = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
    i_tick    = 1'b0;
    total++;
    if ({o_timeout, o_data_b} !== 9'h00A) $display("FAIL tout_byte_wins: got tout=%b b=%h want 0/0a", o_timeout, o_data_b);
    else passed++;
    send_byte(8'h20);
    @(negedge clk);
    total++;
    if ({o_tx_start, o_tx_data} !== 9'h113) $display("FAIL tout_byte_wins_tx: got start=%b data=%h want 1/13", o_tx_start, o_tx_data);
    else passed++;
    pulse_tx_done();
  endtask
`else
  task automatic test_no_timeout();
    logic seen = 1'b0;
    send_byte(8'h07);
    for (int i = 0; i < 1000; i++) begin
      pulse_tick();
      if (o_timeout !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL no_tout_pulse: got %b want 0", seen);
    else passed++;
    send_byte(8'h01);
    send_byte(8'h20);
    @(negedge clk);
    total++;
    if ({o_tx_start, o_tx_data} !== 9'h108) $display("FAIL no_tout_tx: got start=%b data=%h want 1/08", o_tx_start, o_tx_data);
    else passed++;
    pulse_tx_done();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_opcode_mask();
    test_overrun();
    test_async_reset();
    test_simultaneous();
`ifdef UART_ALU_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
